// File: rtl/attn_v_head_scheduler.sv
// Head sequencer for the Attn@V engine: owns the two ping-pong attention banks,
// gates the engine's empty flag and steps the per-head ValueRAM base across a layer.
//
// state | meaning
// IDLE  | no layer in flight, waiting for i_layer_start
// WAIT  | head selected, waiting for the read bank to be filled
// RUN   | engine consuming the read bank (empty flag low)
// DRAIN | bank released, waiting for the head's last output spike
// DONE  | one-cycle layer-done pulse
module attn_v_head_scheduler #(
    parameter int HEAD_NUMS         = 8,
    parameter int HEAD_W            = 3,
    parameter int VALUE_HEAD_STRIDE = 16,
    parameter int VADDR_W           = 10
) (
    input  logic               s_clk,
    input  logic               s_rst,
    input  logic               i_layer_start,
    output logic               o_wr_bank_sel,
    output logic               o_wr_ready,
    input  logic               i_wr_bank_done,
    output logic               o_rd_bank_sel,
    output logic               o_attnram_empty,
    input  logic               i_attnram_done,
    input  logic               i_head_spikes_done,
    output logic [HEAD_W-1:0]  o_head_idx,
    output logic [VADDR_W-1:0] o_value_base_addr,
    output logic               o_busy,
    output logic               o_layer_done,
    output logic               o_err_overwrite
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [HEAD_W-1:0]  LAST_HEAD = HEAD_W'(HEAD_NUMS - 1);
    localparam logic [VADDR_W-1:0] STRIDE_V  = VADDR_W'(VALUE_HEAD_STRIDE);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        bank_full;
    logic              wr_sel;
    logic              rd_sel;
    logic [HEAD_W-1:0] head_idx;
    logic [HEAD_W-1:0] head_nxt;
    logic              wr_accept;
    logic              wr_reject;
    logic              rd_release;
    logic              layer_go;
    logic              head_adv;

    assign o_wr_ready = ~bank_full[wr_sel];
    assign wr_accept  = i_wr_bank_done & o_wr_ready;
    assign wr_reject  = i_wr_bank_done & ~o_wr_ready;
    assign rd_release = (state == ST_RUN) & i_attnram_done;
    assign layer_go   = (state == ST_IDLE) & i_layer_start;
    assign head_adv   = (state == ST_DRAIN) & i_head_spikes_done & (head_idx != LAST_HEAD);
    assign head_nxt   = head_idx + 1'b1;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_layer_start) state_nxt = ST_WAIT;
            ST_WAIT:  if (bank_full[rd_sel]) state_nxt = ST_RUN;
            ST_RUN:   if (i_attnram_done) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (i_head_spikes_done) begin
                    state_nxt = (head_idx == LAST_HEAD) ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Set and clear can never target the same bank: a full read bank blocks the writer.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            bank_full <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            if (wr_accept) begin
                bank_full[wr_sel] <= 1'b1;
                wr_sel            <= ~wr_sel;
            end
            if (rd_release) begin
                bank_full[rd_sel] <= 1'b0;
                rd_sel            <= ~rd_sel;
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            head_idx          <= '0;
            o_value_base_addr <= '0;
        end else if (layer_go) begin
            head_idx          <= '0;
            o_value_base_addr <= '0;
        end else if (head_adv) begin
            head_idx          <= head_nxt;
            o_value_base_addr <= VADDR_W'(head_nxt) * STRIDE_V;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            o_err_overwrite <= 1'b0;
        end else if (wr_reject) begin
            o_err_overwrite <= 1'b1;
        end else if (layer_go) begin
            o_err_overwrite <= 1'b0;
        end
    end

    assign o_wr_bank_sel   = wr_sel;
    assign o_rd_bank_sel   = rd_sel;
    assign o_head_idx      = head_idx;
    assign o_attnram_empty = ~((state == ST_RUN) & bank_full[rd_sel]);
    assign o_busy          = (state != ST_IDLE);
    assign o_layer_done    = (state == ST_DONE);

endmodule
